rvh_l1d_amo_ctrl: RTL and testbench

- Sequencing stage for RISC-V A-extension AMOs inside the L1D, directly upstream of the L1D integer ALU.
- Takes one AMO request carrying the old dword from the cache data read plus rs2, and extracts and extends the operands.
- Drives the combinational ALU and registers its result. For MIN/MAX it selects old or rs2 from the ALU set-less-than result.
- Returns the merged write dword, byte mask and rd value to the cache write-back path.

---
 rtl/rvh_l1d_pkg.sv | 52 +++++
 rtl/rvh_l1d_amo_operand_ext.sv | 43 ++++
 rtl/rvh_l1d_amo_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rvh_l1d_amo_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions used by the AMO sequencing stage.
// This file holds the AMO opcode enum, the ALU opcode constants and the AMO FSM state type.
// It also provides helpers that normalise an AMO opcode and map it to an ALU opcode.
package rvh_l1d_pkg;

    typedef enum logic [3:0] {
        AMO_SWAP = 4'd0,
        AMO_ADD  = 4'd1,
        AMO_AND  = 4'd2,
        AMO_OR   = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_MIN  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MINU = 4'd7,
        AMO_MAXU = 4'd8
    } amo_op_e;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SLT  = 5'd12;
    localparam logic [4:0] ALU_SLTU = 5'd13;
    localparam logic [4:0] ALU_AND  = 5'd14;
    localparam logic [4:0] ALU_OR   = 5'd15;
    localparam logic [4:0] ALU_XOR  = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } amo_state_e;

    // Encodings outside the defined set behave as AMOADD.
    function automatic amo_op_e amo_op_normalize(input logic [3:0] raw);
        if (raw > 4'd8) begin
            return AMO_ADD;
        end
        return amo_op_e'(raw);
    endfunction

    // MIN/MAX variants use the ALU compare.
    // The old-or-rs2 selection happens after the compare.
    function automatic logic [4:0] amo_alu_opcode(input amo_op_e op);
        case (op)
            AMO_AND:            return ALU_AND;
            AMO_OR:             return ALU_OR;
            AMO_XOR:            return ALU_XOR;
            AMO_MIN, AMO_MAX:   return ALU_SLT;
            AMO_MINU, AMO_MAXU: return ALU_SLTU;
            default:            return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/rvh_l1d_amo_operand_ext.sv
// Operand extraction and extension for the AMO stage, plus the misalignment check.
// For a .W access, this picks the addressed word of the old dword and the low word of rs2.
// Unsigned compares (MINU/MAXU) zero-extend these words; every other op sign-extends them.
// The rd value for .W is always sign-extended, as the ISA requires for the loaded word.
module rvh_l1d_amo_operand_ext
    import rvh_l1d_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      op,
    input  logic            is_w,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] old_data,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] old_ext,
    output logic [XLEN-1:0] rs2_ext,
    output logic [XLEN-1:0] rd_ext,
    output logic            misalign
);

    logic [31:0] old32;
    logic [31:0] rs2_32;
    logic        zero_ext;

    // Select the words, extend them per op signedness and flag misaligned addresses.
    always_comb begin
        old32    = offset[2] ? old_data[32 +: 32] : old_data[0 +: 32];
        rs2_32   = rs2[31:0];
        zero_ext = (op == AMO_MINU) || (op == AMO_MAXU);
        if (is_w) begin
            old_ext  = zero_ext ? {{(XLEN-32){1'b0}}, old32}  : {{(XLEN-32){old32[31]}}, old32};
            rs2_ext  = zero_ext ? {{(XLEN-32){1'b0}}, rs2_32} : {{(XLEN-32){rs2_32[31]}}, rs2_32};
            rd_ext   = {{(XLEN-32){old32[31]}}, old32};
            misalign = (offset[1:0] != 2'b00);
        end else begin
            old_ext  = old_data;
            rs2_ext  = rs2;
            rd_ext   = old_data;
            misalign = (offset != 3'b000);
        end
    end

endmodule

// File: rtl/rvh_l1d_amo_ctrl.sv
// AMO sequencing stage that sits directly upstream of the L1D integer ALU.
// It captures one AMO and drives the combinational ALU for exactly one cycle.
// It then returns the merged write dword, the byte mask and the rd value.
// Optional macro RVH_L1D_AMO_B2B_EN: lets a new request be accepted in the same cycle as the response handshake.
module rvh_l1d_amo_ctrl
    import rvh_l1d_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int ALU_OP_WIDTH = 5,
    parameter int AMO_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AMO_OP_WIDTH-1:0] req_amo_op_i,
    input  logic                    req_is_w_i,
    input  logic [2:0]              req_offset_i,
    input  logic [XLEN-1:0]         req_old_data_i,
    input  logic [XLEN-1:0]         req_rs2_i,
    output logic [ALU_OP_WIDTH-1:0] alu_opcode_o,
    output logic                    alu_op_w_o,
    output logic [XLEN-1:0]         alu_operand0_o,
    output logic [XLEN-1:0]         alu_operand1_o,
    input  logic [XLEN-1:0]         alu_result_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [XLEN-1:0]         resp_wdata_o,
    output logic [7:0]              resp_wmask_o,
    output logic [XLEN-1:0]         resp_rd_data_o,
    output logic                    resp_misalign_o
);

    amo_state_e      state;
    amo_op_e         op_q;
    logic            is_w_q;
    logic            off_hi_q;
    logic [XLEN-1:0] old_ext_q;
    logic [XLEN-1:0] rs2_ext_q;
    logic [XLEN-1:0] rd_q;

    amo_op_e         req_op;
    logic [XLEN-1:0] cap_old_ext;
    logic [XLEN-1:0] cap_rs2_ext;
    logic [XLEN-1:0] cap_rd;
    logic            cap_misalign;
    logic [XLEN-1:0] new_val;
    logic            req_fire;

    assign req_op   = amo_op_normalize(req_amo_op_i);
    assign req_fire = req_valid_i & req_ready_o;

    rvh_l1d_amo_operand_ext #(
        .XLEN(XLEN)
    ) u_operand_ext (
        .op       (req_op),
        .is_w     (req_is_w_i),
        .offset   (req_offset_i),
        .old_data (req_old_data_i),
        .rs2      (req_rs2_i),
        .old_ext  (cap_old_ext),
        .rs2_ext  (cap_rs2_ext),
        .rd_ext   (cap_rd),
        .misalign (cap_misalign)
    );

    // Ready in IDLE; with back-to-back enabled also while the response is being consumed.
    always_comb begin
`ifdef RVH_L1D_AMO_B2B_EN
        req_ready_o = (state == IDLE) || ((state == RESP) && resp_ready_i);
`else
        req_ready_o = (state == IDLE);
`endif
    end

    // New memory value: swap takes rs2, min/max choose from the compare bit, the rest take the ALU result.
    always_comb begin
        case (op_q)
            AMO_SWAP:           new_val = rs2_ext_q;
            AMO_MIN, AMO_MINU:  new_val = alu_result_i[0] ? old_ext_q : rs2_ext_q;
            AMO_MAX, AMO_MAXU:  new_val = alu_result_i[0] ? rs2_ext_q : old_ext_q;
            default:            new_val = alu_result_i;
        endcase
    end

    // Main FSM: a capture applied after the state case overrides the RESP->IDLE exit for back-to-back requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            op_q            <= AMO_ADD;
            is_w_q          <= 1'b0;
            off_hi_q        <= 1'b0;
            old_ext_q       <= '0;
            rs2_ext_q       <= '0;
            rd_q            <= '0;
            alu_opcode_o    <= '0;
            alu_op_w_o      <= 1'b0;
            alu_operand0_o  <= '0;
            alu_operand1_o  <= '0;
            resp_valid_o    <= 1'b0;
            resp_wdata_o    <= '0;
            resp_wmask_o    <= 8'h00;
            resp_rd_data_o  <= '0;
            resp_misalign_o <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    alu_opcode_o    <= '0;
                    alu_op_w_o      <= 1'b0;
                    alu_operand0_o  <= '0;
                    alu_operand1_o  <= '0;
                    resp_valid_o    <= 1'b1;
                    resp_misalign_o <= 1'b0;
                    resp_rd_data_o  <= rd_q;
                    if (is_w_q) begin
                        resp_wdata_o <= {2{new_val[31:0]}};
                        resp_wmask_o <= off_hi_q ? 8'hF0 : 8'h0F;
                    end else begin
                        resp_wdata_o <= new_val;
                        resp_wmask_o <= 8'hFF;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o    <= 1'b0;
                        resp_wdata_o    <= '0;
                        resp_wmask_o    <= 8'h00;
                        resp_rd_data_o  <= '0;
                        resp_misalign_o <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (req_fire) begin
                op_q      <= req_op;
                is_w_q    <= req_is_w_i;
                off_hi_q  <= req_offset_i[2];
                old_ext_q <= cap_old_ext;
                rs2_ext_q <= cap_rs2_ext;
                rd_q      <= cap_rd;
                if (cap_misalign) begin
                    resp_valid_o    <= 1'b1;
                    resp_misalign_o <= 1'b1;
                    resp_wdata_o    <= '0;
                    resp_wmask_o    <= 8'h00;
                    resp_rd_data_o  <= '0;
                    state           <= RESP;
                end else begin
                    alu_opcode_o   <= amo_alu_opcode(req_op);
                    alu_op_w_o     <= req_is_w_i & (req_op == AMO_ADD);
                    alu_operand0_o <= cap_old_ext;
                    alu_operand1_o <= cap_rs2_ext;
                    state          <= EXEC;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvh_l1d_amo_ctrl.sv
// Testbench for rvh_l1d_amo_ctrl: uses directed AMO vectors with hand-computed results.
// A small model of the external integer ALU sits behind the DUT's ALU port.
module tb_rvh_l1d_amo_ctrl;
    import rvh_l1d_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_amo_op = 4'd0;
    logic        req_is_w = 1'b0;
    logic [2:0]  req_offset = 3'd0;
    logic [63:0] req_old_data = '0;
    logic [63:0] req_rs2 = '0;
    logic [4:0]  alu_opcode_o;
    logic        alu_op_w_o;
    logic [63:0] alu_operand0_o;
    logic [63:0] alu_operand1_o;
    logic [63:0] alu_result;
    logic        resp_valid_o;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_wdata_o;
    logic [7:0]  resp_wmask_o;
    logic [63:0] resp_rd_data_o;
    logic        resp_misalign_o;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [4:0] exec_opcode;
    logic       exec_op_w;

    rvh_l1d_amo_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_amo_op_i    (req_amo_op),
        .req_is_w_i      (req_is_w),
        .req_offset_i    (req_offset),
        .req_old_data_i  (req_old_data),
        .req_rs2_i       (req_rs2),
        .alu_opcode_o    (alu_opcode_o),
        .alu_op_w_o      (alu_op_w_o),
        .alu_operand0_o  (alu_operand0_o),
        .alu_operand1_o  (alu_operand1_o),
        .alu_result_i    (alu_result),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready),
        .resp_wdata_o    (resp_wdata_o),
        .resp_wmask_o    (resp_wmask_o),
        .resp_rd_data_o  (resp_rd_data_o),
        .resp_misalign_o (resp_misalign_o)
    );

    always #5 clk = ~clk;

    // Reference model of the downstream combinational integer ALU
    logic [31:0] sum32;
    always_comb begin
        sum32      = alu_operand0_o[31:0] + alu_operand1_o[31:0];
        alu_result = '0;
        case (alu_opcode_o)
            ALU_ADD:  alu_result = alu_op_w_o ? {{32{sum32[31]}}, sum32} : alu_operand0_o + alu_operand1_o;
            ALU_SLT:  alu_result = {63'd0, $signed(alu_operand0_o) < $signed(alu_operand1_o)};
            ALU_SLTU: alu_result = {63'd0, alu_operand0_o < alu_operand1_o};
            ALU_AND:  alu_result = alu_operand0_o & alu_operand1_o;
            ALU_OR:   alu_result = alu_operand0_o | alu_operand1_o;
            ALU_XOR:  alu_result = alu_operand0_o ^ alu_operand1_o;
            default:  alu_result = '0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Issue one AMO, note the ALU controls one cycle after accept, and count cycles to resp_valid
    task automatic applyStimulus(input logic [3:0] op, input logic is_w, input logic [2:0] off,
                                 input logic [63:0] old, input logic [63:0] rs2);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_amo_op   = op;
        req_is_w     = is_w;
        req_offset   = off;
        req_old_data = old;
        req_rs2      = rs2;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        lat         = 1;
        exec_opcode = alu_opcode_o;
        exec_op_w   = alu_op_w_o;
        n = 0;
        while (!resp_valid_o && n < 10) begin
            @(posedge clk);
            #1;
            lat++;
            n++;
        end
    endtask

    task automatic finishResp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("resp_drop", {63'd0, resp_valid_o}, 64'd0);
    endtask

    task automatic checkResp(input string tag, input int exp_lat, input logic [4:0] exp_opc,
                             input logic [63:0] wdata, input logic [7:0] wmask,
                             input logic [63:0] rd, input logic mis);
        checkOutput({tag, "_lat"},   64'(lat), 64'(exp_lat));
        checkOutput({tag, "_opc"},   {59'd0, exec_opcode}, {59'd0, exp_opc});
        checkOutput({tag, "_wdata"}, resp_wdata_o, wdata);
        checkOutput({tag, "_wmask"}, {56'd0, resp_wmask_o}, {56'd0, wmask});
        checkOutput({tag, "_rd"},    resp_rd_data_o, rd);
        checkOutput({tag, "_mis"},   {63'd0, resp_misalign_o}, {63'd0, mis});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int acc[2];
        int n_acc;
        logic [63:0] held;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_valid",  {63'd0, resp_valid_o}, 64'd0);
        checkOutput("rst_wmask",  {56'd0, resp_wmask_o}, 64'd0);
        checkOutput("rst_mis",    {63'd0, resp_misalign_o}, 64'd0);
        checkOutput("rst_aluop0", alu_operand0_o, 64'd0);
        checkOutput("rst_alu_w",  {63'd0, alu_op_w_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", {63'd0, req_ready_o}, 64'd1);

        // AMOADD.D 1 + -1
        applyStimulus(4'd1, 1'b0, 3'd0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        checkResp("addd", 2, ALU_ADD, 64'h0, 8'hFF, 64'h1, 1'b0);
        checkOutput("addd_opw", {63'd0, exec_op_w}, 64'd0);
        finishResp();

        // AMOADD.W low word overflow, upper old half ignored
        applyStimulus(4'd1, 1'b1, 3'd0, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0001);
        checkResp("addw", 2, ALU_ADD, 64'h8000_0000_8000_0000, 8'h0F, 64'h0000_0000_7FFF_FFFF, 1'b0);
        checkOutput("addw_opw", {63'd0, exec_op_w}, 64'd1);
        finishResp();

        // AMOMIN.W upper word, signed
        applyStimulus(4'd5, 1'b1, 3'd4, 64'h8000_0000_1234_5678, 64'h1);
        checkResp("minw", 2, ALU_SLT, 64'h8000_0000_8000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        checkOutput("minw_opw", {63'd0, exec_op_w}, 64'd0);
        finishResp();

        // AMOMINU.W same operands, unsigned picks rs2
        applyStimulus(4'd7, 1'b1, 3'd4, 64'h8000_0000_1234_5678, 64'h1);
        checkResp("minuw", 2, ALU_SLTU, 64'h0000_0001_0000_0001, 8'hF0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        finishResp();

        // AMOMAX.D 5 vs -3
        applyStimulus(4'd6, 1'b0, 3'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD);
        checkResp("maxd", 2, ALU_SLT, 64'd5, 8'hFF, 64'd5, 1'b0);
        finishResp();

        // AMOXOR.D
        applyStimulus(4'd4, 1'b0, 3'd0, 64'hF0F0, 64'h0FF0);
        checkResp("xord", 2, ALU_XOR, 64'hFF00, 8'hFF, 64'hF0F0, 1'b0);
        finishResp();

        // AMOMAXU.D 5 vs big, then hold off the consumer for 5 cycles
        applyStimulus(4'd8, 1'b0, 3'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD);
        checkResp("maxud", 2, ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFD, 8'hFF, 64'd5, 1'b0);
        held = 64'hFFFF_FFFF_FFFF_FFFD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", {63'd0, resp_valid_o}, 64'd1);
            checkOutput("bp_wdata", resp_wdata_o, held);
            checkOutput("bp_ready", {63'd0, req_ready_o}, 64'd0);
        end
        finishResp();

        // AMOSWAP.W misaligned
        applyStimulus(4'd0, 1'b1, 3'd2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        checkResp("swapmis", 1, 5'd0, 64'h0, 8'h00, 64'h0, 1'b1);
        finishResp();

        // Back-to-back request spacing with the consumer always ready
        @(negedge clk);
        resp_ready   = 1'b1;
        req_valid    = 1'b1;
        req_amo_op   = 4'd1;
        req_is_w     = 1'b0;
        req_offset   = 3'd0;
        req_old_data = 64'd2;
        req_rs2      = 64'd3;
        n_acc = 0;
        acc[0] = 0;
        acc[1] = 0;
        for (int c = 0; c < 20 && n_acc < 2; c++) begin
            if (req_ready_o) begin
                acc[n_acc] = c;
                n_acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("b2b_count", 64'(n_acc), 64'd2);
`ifdef RVH_L1D_AMO_B2B_EN
        checkOutput("b2b_gap", 64'(acc[1] - acc[0]), 64'd2);
`else
        checkOutput("b2b_gap", 64'(acc[1] - acc[0]), 64'd3);
`endif
        repeat (5) @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("b2b_drain", {63'd0, resp_valid_o}, 64'd0);

        // Reset asserted while in EXEC
        @(negedge clk);
        req_valid    = 1'b1;
        req_amo_op   = 4'd1;
        req_is_w     = 1'b0;
        req_offset   = 3'd0;
        req_old_data = 64'd7;
        req_rs2      = 64'd8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("exec_op0", alu_operand0_o, 64'd7);
        rst = 1'b1;
        #1;
        checkOutput("rstx_valid", {63'd0, resp_valid_o}, 64'd0);
        checkOutput("rstx_op0",   alu_operand0_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstx_still", {63'd0, resp_valid_o}, 64'd0);
        checkOutput("rstx_ready", {63'd0, req_ready_o}, 64'd1);

        // Normal AMO after the aborted one
        applyStimulus(4'd1, 1'b0, 3'd0, 64'd10, 64'd20);
        checkResp("post", 2, ALU_ADD, 64'd30, 8'hFF, 64'd10, 1'b0);
        finishResp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
